// File: rtl/heli_game_ctrl_pkg.sv
// Purpose: shared state encodings, screen geometry and physics constants for the helicopter game.
// Latency: n/a (types, constants and one combinational helper function).
// Backpressure: n/a.
package heli_game_ctrl_pkg;

  // Game states; PAUSE is only reachable when the pause feature is built in.
  typedef enum logic [2:0] {
    INIT  = 3'b000,
    PLAY  = 3'b001,
    NEWHS = 3'b010,
    DEAD  = 3'b011,
    PAUSE = 3'b100
  } state_t;

  // Screen geometry, shared with the renderer.
  localparam int SCREEN_H = 480;
  localparam int PLAYER_H = 16;

  // Physics and scoring.
  localparam int GRAV        = 1;
  localparam int LIFT_ACC    = 2;
  localparam int VMAX        = 8;
  localparam int SCORE_DIV   = 8;
  localparam int HOLD_FRAMES = 120;

  localparam logic [9:0] Y_MAX   = 10'(SCREEN_H - PLAYER_H);
  localparam logic [9:0] Y_START = 10'((SCREEN_H - PLAYER_H) / 2);
  localparam logic [9:0] SCORE_MAX = 10'h3FF;

  localparam int DIV_W  = $clog2(SCORE_DIV);
  localparam int HOLD_W = $clog2(HOLD_FRAMES);

  localparam logic signed [6:0] GRAV_STEP = 7'(GRAV);
  localparam logic signed [6:0] LIFT_STEP = 7'(LIFT_ACC);
  localparam logic signed [6:0] VMAX_P    = 7'(VMAX);
  localparam logic signed [6:0] VMAX_N    = -VMAX_P;

  // One frame of velocity update: accelerate up while lift is held, fall
  // otherwise, then clamp the magnitude. Worked in 7 bits so the step can
  // never wrap before the clamp sees it.
  function automatic logic signed [5:0] vel_step(input logic signed [5:0] v,
                                                 input logic              lift_held);
    logic signed [6:0] t;
    t = {v[5], v};
    if (lift_held) t = t - LIFT_STEP;
    else           t = t + GRAV_STEP;
    if (t > VMAX_P) t = VMAX_P;
    if (t < VMAX_N) t = VMAX_N;
    vel_step = t[5:0];
  endfunction

endpackage

// File: rtl/heli_game_ctrl_edge.sv
// Purpose: registered edge detector; one-cycle pulse on a rising (FALL=0) or falling (FALL=1) input edge.
// Latency: pulse is high for the clock cycle after the input change is first registered.
// Backpressure: none; free-running on every clock.
module heli_edge_det #(
  parameter bit FALL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic pulse_o
);

  logic s1_q;
  logic s2_q;

  // Two-stage history; on reset both stages load the live input so that a
  // level already present at reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= sig_i;
      s2_q <= sig_i;
    end else begin
      s1_q <= sig_i;
      s2_q <= s1_q;
    end
  end

  assign pulse_o = FALL ? (~s1_q & s2_q) : (s1_q & ~s2_q);

endmodule

// File: rtl/heli_game_ctrl.sv
// Purpose: helicopter game sequencer - game FSM, per-frame player physics, score and high score.
// Latency: start edge -> PLAY 2 clocks later; frame-tick results visible 2 clocks after vga_v_sync falls.
// Backpressure: none; inputs are levels, game work is gated by the frame tick. Optional pause: HELI_PAUSE_EN.
module heli_game_ctrl
  import heli_game_ctrl_pkg::*;
(
  input  logic       ClkPort,
  input  logic       reset_n,
  input  logic       start,
  input  logic       lift,
  input  logic       vga_v_sync,
  input  logic       collision,
`ifdef HELI_PAUSE_EN
  input  logic       pause,
`endif
  output logic [2:0] state,
  output logic [9:0] player_y,
  output logic [9:0] player_score,
  output logic [9:0] high_score,
  output logic       hs_flag,
  output logic       scroll_en,
  output logic       game_over
);

  state_t             state_q, state_d;
  logic signed [5:0]  vel_q, vel_d;
  logic [9:0]         py_q, py_d;
  logic [9:0]         score_q, score_d;
  logic [9:0]         hs_q, hs_d;
  logic               hsf_q, hsf_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               go_q, go_d;
  logic               scroll_q, scroll_d;

  logic               start_rise;
  logic               frame_tick;

  // Candidate results of one PLAY frame, computed unconditionally.
  logic signed [5:0]  vel_nx;
  logic [10:0]        ny;
  logic               ny_low;
  logic               ny_high;
  logic               div_wrap;
  logic [DIV_W-1:0]   div_nx;
  logic [9:0]         score_nx;
  logic               hold_done;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCORE_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

  heli_edge_det #(.FALL(1'b0)) u_start_edge (
    .clk     (ClkPort),
    .rst_n   (reset_n),
    .sig_i   (start),
    .pulse_o (start_rise)
  );

  heli_edge_det #(.FALL(1'b1)) u_vsync_edge (
    .clk     (ClkPort),
    .rst_n   (reset_n),
    .sig_i   (vga_v_sync),
    .pulse_o (frame_tick)
  );

`ifdef HELI_PAUSE_EN
  logic pause_rise;

  heli_edge_det #(.FALL(1'b0)) u_pause_edge (
    .clk     (ClkPort),
    .rst_n   (reset_n),
    .sig_i   (pause),
    .pulse_o (pause_rise)
  );
`endif

  // Physics and score candidates for the current frame.
  always_comb begin
    vel_nx   = vel_step(vel_q, lift);
    // py is at most Y_MAX (< 512), so bit 10 of the sum is a clean sign bit.
    ny       = {1'b0, py_q} + {{5{vel_nx[5]}}, vel_nx};
    ny_low   = ny[10];
    ny_high  = !ny[10] && (ny[9:0] > Y_MAX);
    div_wrap = (div_q == DIV_LAST);
    div_nx   = div_wrap ? '0 : div_q + 1'b1;
    score_nx = (div_wrap && score_q != SCORE_MAX) ? score_q + 10'd1 : score_q;
    hold_done = frame_tick && (hold_q == HOLD_LAST);
  end

  // Next-state and datapath update for the game FSM.
  always_comb begin
    state_d = state_q;
    vel_d   = vel_q;
    py_d    = py_q;
    score_d = score_q;
    hs_d    = hs_q;
    hsf_d   = hsf_q;
    div_d   = div_q;
    hold_d  = hold_q;
    go_d    = 1'b0;

    case (state_q)
      INIT: begin
        vel_d   = '0;
        py_d    = Y_START;
        score_d = '0;
        hsf_d   = 1'b0;
        div_d   = '0;
        hold_d  = '0;
        if (start_rise) state_d = PLAY;
      end

      PLAY: begin
        if (frame_tick) begin
          vel_d   = vel_nx;
          py_d    = ny_low ? 10'd0 : (ny_high ? Y_MAX : ny[9:0]);
          score_d = score_nx;
          div_d   = div_nx;
          hsf_d   = (score_nx > hs_q);
          // A hit ends the run on this very frame; it outranks a pause request.
          if (collision || ny_low || ny_high) begin
            go_d    = 1'b1;
            state_d = (score_nx > hs_q) ? NEWHS : DEAD;
          end
`ifdef HELI_PAUSE_EN
          else if (pause_rise) begin
            state_d = PAUSE;
          end
`endif
        end
`ifdef HELI_PAUSE_EN
        else if (pause_rise) begin
          state_d = PAUSE;
        end
`endif
      end

      NEWHS: begin
        // Score is frozen here, so latching every cycle equals latching on entry.
        hs_d = score_q;
        if (hold_done) begin
          hold_d  = '0;
          hsf_d   = 1'b0;
          state_d = INIT;
        end else if (frame_tick) begin
          hold_d = hold_q + 1'b1;
        end
      end

      DEAD: begin
        if (hold_done) begin
          hold_d  = '0;
          hsf_d   = 1'b0;
          state_d = INIT;
        end else if (frame_tick) begin
          hold_d = hold_q + 1'b1;
        end
      end

`ifdef HELI_PAUSE_EN
      PAUSE: begin
        if (pause_rise) state_d = PLAY;
      end
`endif

      default: begin
        state_d = INIT;
      end
    endcase

    scroll_d = (state_d == PLAY);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge ClkPort) begin
    if (!reset_n) begin
      state_q  <= INIT;
      vel_q    <= '0;
      py_q     <= Y_START;
      score_q  <= '0;
      hs_q     <= '0;
      hsf_q    <= 1'b0;
      div_q    <= '0;
      hold_q   <= '0;
      go_q     <= 1'b0;
      scroll_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      vel_q    <= vel_d;
      py_q     <= py_d;
      score_q  <= score_d;
      hs_q     <= hs_d;
      hsf_q    <= hsf_d;
      div_q    <= div_d;
      hold_q   <= hold_d;
      go_q     <= go_d;
      scroll_q <= scroll_d;
    end
  end

  assign state        = state_q;
  assign player_y     = py_q;
  assign player_score = score_q;
  assign high_score   = hs_q;
  assign hs_flag      = hsf_q;
  assign scroll_en    = scroll_q;
  assign game_over    = go_q;

endmodule
